multi_chan_pwm_gen: RTL and testbench

//  Parametrised N-channel PWM generator sharing one period counter. Successor to
//  the fixed-frequency 8-bit single-channel generator.

---
 rtl/multi_chan_pwm_gen.sv | 122 ++++++++++++
 tb/tb_multi_chan_pwm_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_chan_pwm_gen.sv
// N-channel PWM generator sharing one prescaled period counter, with edge or
// centre alignment, shadowed top/duty/mode registers and per-channel polarity.
module multi_chan_pwm_gen #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PSC_W    = 8,
    parameter logic [CHANNELS-1:0] INVERT = '0
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      enable,
    input  logic                      center,
    input  logic [PSC_W-1:0]          prescale,
    input  logic [WIDTH-1:0]          top,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_end
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [PSC_W-1:0]    psc_cnt;
    logic [WIDTH-1:0]    cnt;
    dir_t                dir;
    logic [WIDTH-1:0]    top_a;
    logic                center_a;
    logic [WIDTH-1:0]    duty_a [CHANNELS];

    logic                tick;
    logic [WIDTH-1:0]    t_peak;
    logic [WIDTH-1:0]    cnt_next;
    dir_t                dir_next;
    logic                at_boundary;
    logic [CHANNELS-1:0] active;

    assign tick   = (psc_cnt == prescale);
    assign t_peak = (top_a == '0) ? WIDTH'(1) : top_a;

    // Next counter step, applied only on ticks; at_boundary marks the last tick of a period.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_next    = cnt;
        dir_next    = dir;
        at_boundary = 1'b0;
        if (center_a) begin
            if (dir == DIR_DOWN) begin
                if (cnt == WIDTH'(1)) begin
                    at_boundary = 1'b1;
                    cnt_next    = '0;
                    dir_next    = DIR_UP;
                end else begin
                    cnt_next = cnt - WIDTH'(1);
                end
            end else begin
                cnt_next = cnt + WIDTH'(1);
                if (cnt_next == t_peak) begin
                    dir_next = DIR_DOWN;
                end
            end
        end else if (cnt == top_a) begin
            at_boundary = 1'b1;
            cnt_next    = '0;
            dir_next    = DIR_UP;
        end else begin
            cnt_next = cnt + WIDTH'(1);
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            active[i] = (cnt < duty_a[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            psc_cnt    <= '0;
            cnt        <= '0;
            dir        <= DIR_UP;
            top_a      <= '0;
            center_a   <= 1'b0;
            pwm        <= INVERT;
            period_end <= 1'b0;
            // NOTE: the shadow duty array is a handful of flops, not a RAM, so it is safe to reset.
            for (int i = 0; i < CHANNELS; i++) begin
                duty_a[i] <= '0;
            end
        end else if (!enable) begin
            psc_cnt    <= '0;
            cnt        <= '0;
            dir        <= DIR_UP;
            pwm        <= INVERT;
            period_end <= 1'b0;
            top_a      <= top;
            center_a   <= center;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_a[i] <= duty[i*WIDTH +: WIDTH];
            end
        end else begin
            pwm        <= INVERT ^ active;
            period_end <= tick && at_boundary;
            if (tick) begin
                psc_cnt <= '0;
                cnt     <= cnt_next;
                dir     <= dir_next;
                // Shadow reload only at a period boundary so a live period is never glitched.
                if (at_boundary) begin
                    top_a    <= top;
                    center_a <= center;
                    for (int i = 0; i < CHANNELS; i++) begin
                        duty_a[i] <= duty[i*WIDTH +: WIDTH];
                    end
                end
            end else begin
                psc_cnt <= psc_cnt + PSC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_chan_pwm_gen.sv
// Bench for multi_chan_pwm_gen: period-position reference model checked every
// clock, plus directed scenarios pinned with hand-computed counts.
module tb_multi_chan_pwm_gen;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int PSC_W    = 8;
    localparam logic [CHANNELS-1:0] INVERT = 4'b0010;

    logic                      clock    = 1'b0;
    logic                      resetN   = 1'b0;
    logic                      enable   = 1'b0;
    logic                      center   = 1'b0;
    logic [PSC_W-1:0]          prescale = '0;
    logic [WIDTH-1:0]          top      = '0;
    logic [CHANNELS*WIDTH-1:0] duty     = '0;
    logic [CHANNELS-1:0]       pwm;
    logic                      period_end;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multi_chan_pwm_gen #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PSC_W(PSC_W), .INVERT(INVERT)
    ) dut (
        .clock(clock), .resetN(resetN), .enable(enable), .center(center),
        .prescale(prescale), .top(top), .duty(duty),
        .pwm(pwm), .period_end(period_end)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the period in ticks, counter value derived from it.
    int          m_psc, m_pos, m_top, m_center;
    int          m_duty [CHANNELS];
    logic [CHANNELS-1:0] exp_pwm;
    logic        exp_pe;

    function automatic int model_cnt();
        int t;
        if (m_center == 0) return m_pos;
        t = (m_top == 0) ? 1 : m_top;
        return (m_pos <= t) ? m_pos : 2 * t - m_pos;
    endfunction

    task automatic model_load();
        m_top    = int'(top);
        m_center = int'(center);
        for (int i = 0; i < CHANNELS; i++) m_duty[i] = int'(duty[i*WIDTH +: WIDTH]);
    endtask

    always @(posedge clock) begin
        int c;
        int plen;
        if (!resetN) begin
            m_psc = 0; m_pos = 0; m_top = 0; m_center = 0;
            for (int i = 0; i < CHANNELS; i++) m_duty[i] = 0;
            exp_pwm = INVERT;
            exp_pe  = 1'b0;
        end else if (!enable) begin
            m_psc = 0; m_pos = 0;
            model_load();
            exp_pwm = INVERT;
            exp_pe  = 1'b0;
        end else begin
            c = model_cnt();
            for (int i = 0; i < CHANNELS; i++) exp_pwm[i] = INVERT[i] ^ (c < m_duty[i]);
            exp_pe = 1'b0;
            if (m_psc == int'(prescale)) begin
                m_psc = 0;
                plen  = (m_center != 0) ? 2 * ((m_top == 0) ? 1 : m_top) : m_top + 1;
                if (m_pos + 1 == plen) begin
                    m_pos  = 0;
                    exp_pe = 1'b1;
                    model_load();
                end else begin
                    m_pos++;
                end
            end else begin
                m_psc = (m_psc + 1) % 256;
            end
        end
        #1;
        check("model_pwm", 32'(pwm), 32'(exp_pwm));
        check("model_period_end", 32'(period_end), 32'(exp_pe));
    end

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty = {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
    endtask

    // Load new settings through idle, then run a few clocks to settle.
    task automatic restart(input int ps, input int tp, input logic ctr,
                           input int d0, input int d1, input int d2, input int d3);
        @(negedge clock);
        enable   = 1'b0;
        prescale = PSC_W'(ps);
        top      = WIDTH'(tp);
        center   = ctr;
        set_duty(d0, d1, d2, d3);
        repeat (2) @(negedge clock);
        enable = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic measure(input int n, output int hi0, output int hi1, output int hi2, output int npe);
        hi0 = 0; hi1 = 0; hi2 = 0; npe = 0;
        repeat (n) begin
            @(posedge clock); #1;
            hi0 += int'(pwm[0]);
            hi1 += int'(pwm[1]);
            hi2 += int'(pwm[2]);
            npe += int'(period_end);
        end
    endtask

    initial begin
        int h0, h1, h2, pe, hi_a, hi_b, waited;
        bit found;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_pwm", 32'(pwm), 32'h2);
        check("reset_period_end", 32'(period_end), 32'h0);
        resetN = 1'b1;

        // T1 edge: top=9, duty0=3
        restart(0, 9, 1'b0, 3, 0, 0, 0);
        measure(30, h0, h1, h2, pe);
        check("t1_high", h0, 9);
        check("t1_period_ends", pe, 3);

        // T2 extremes: duty 0, top+1, 255
        restart(0, 9, 1'b0, 0, 10, 255, 0);
        measure(20, h0, h1, h2, pe);
        check("t2_duty0_off", h0, 0);
        check("t2_duty_top1_on_inverted", h1, 0);
        check("t2_duty255_on", h2, 20);

        // T3 prescale=3, top=4, duty0=2
        restart(3, 4, 1'b0, 2, 0, 0, 0);
        measure(40, h0, h1, h2, pe);
        check("t3_high", h0, 16);
        check("t3_period_ends", pe, 2);

        // T4 centre: top=5, duty0=2
        restart(0, 5, 1'b1, 2, 0, 0, 0);
        measure(30, h0, h1, h2, pe);
        check("t4_high", h0, 9);
        check("t4_period_ends", pe, 3);

        // T5 shadow: duty0 3 -> 7 at cnt=5
        restart(0, 9, 1'b0, 3, 0, 0, 0);
        found = 1'b0;
        waited = 0;
        while (!found && waited < 100) begin
            @(posedge clock); #1;
            found = period_end;
            waited++;
        end
        check("t5_period_end_seen", 32'(found), 32'h1);
        hi_a = 0;
        hi_b = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clock); #1;
            if (j <= 10) hi_a += int'(pwm[0]);
            else         hi_b += int'(pwm[0]);
            if (j == 5) begin
                @(negedge clock);
                set_duty(7, 0, 0, 0);
            end
        end
        check("t5_current_period_high", hi_a, 3);
        check("t5_next_period_high", hi_b, 7);

        // T6: reset mid-period, idle, then restart from cnt=0
        restart(0, 9, 1'b0, 3, 0, 0, 0);
        repeat (4) @(negedge clock);
        resetN = 1'b0;
        #1;
        check("t6_async_reset_pwm", 32'(pwm), 32'h2);
        check("t6_async_reset_pe", 32'(period_end), 32'h0);
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        check("t6_idle_pwm", 32'(pwm), 32'h2);
        enable = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clock); #1;
            check("t6_restart_pwm0", 32'(pwm[0]), (j < 3) ? 32'h1 : 32'h0);
        end

        // Randomised operation, including live input changes and enable/reset toggling
        for (int seg = 0; seg < 40; seg++) begin
            @(negedge clock);
            case ($urandom_range(0, 9))
                0:       enable = ~enable;
                1:       begin resetN = 1'b0; @(negedge clock); resetN = 1'b1; end
                default: enable = 1'b1;
            endcase
            prescale = PSC_W'($urandom_range(0, 3));
            top      = WIDTH'($urandom_range(0, 12));
            center   = 1'($urandom_range(0, 1));
            set_duty($urandom_range(0, 14), $urandom_range(0, 14),
                     $urandom_range(0, 14), $urandom_range(0, 14));
            repeat ($urandom_range(5, 60)) @(negedge clock);
        end

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
